// File: rtl/rf_ctrl_pkg.sv
// Shared widths, limits and types for the register-file writeback controller.
package rf_ctrl_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned NREGS        = 32;
  localparam int unsigned AW           = 5;
  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned SW           = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_REQ0 = 2'd1,
    GNT_REQ1 = 2'd2
  } grant_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy bit per architectural register: set on reservation, cleared when the
// register file write lands, with three combinational lookup ports.
module regfile_scoreboard
  import rf_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [AW-1:0]    set_idx,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_idx,
  input  logic [AW-1:0]    lk_a_idx,
  input  logic [AW-1:0]    lk_b_idx,
  input  logic [AW-1:0]    lk_c_idx,
  output logic             lk_a_busy,
  output logic             lk_b_busy,
  output logic             lk_c_busy,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] busy_q, busy_d;

  // Set is applied after clear so a same-edge collision leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign lk_a_busy = busy_q[lk_a_idx];
  assign lk_b_busy = busy_q[lk_b_idx];
  assign lk_c_busy = busy_q[lk_c_idx];
  assign busy      = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the register file write port: arbitrates ALU vs long-latency writeback,
// registers the winner onto WE3/A3/WD3 and raises hazard_stall from the scoreboard.
module regfile_wb_arbiter
  import rf_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic            rsv_valid,
  input  logic [AW-1:0]   rsv_rd,
  output logic            hazard_stall,
  input  logic            req0_valid,
  input  logic [AW-1:0]   req0_rd,
  input  logic [XLEN-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [AW-1:0]   req1_rd,
  input  logic [XLEN-1:0] req1_data,
  output logic            req1_ready,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  grant_e          grant;
  wb_req_t         wb_sel;
  logic            wb_fire;
  logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            rs1_busy, rs2_busy, rsv_busy;
  logic            rsv_take;
  logic [NREGS-1:0] busy;

  always_comb begin
    grant = GNT_NONE;
    if (req1_valid && (!req0_valid || starve_cnt_q == SW'(STARVE_LIMIT)))
      grant = GNT_REQ1;
    else if (req0_valid)
      grant = GNT_REQ0;
  end

  assign req0_ready = (grant == GNT_REQ0);
  assign req1_ready = (grant == GNT_REQ1);

  always_comb begin
    wb_sel  = (grant == GNT_REQ1) ? '{rd: req1_rd, data: req1_data}
                                  : '{rd: req0_rd, data: req0_data};
    wb_fire = (grant != GNT_NONE);

    starve_cnt_d = '0;
    if (req1_valid && grant != GNT_REQ1)
      starve_cnt_d = (starve_cnt_q == SW'(STARVE_LIMIT)) ? starve_cnt_q
                                                        : starve_cnt_q + 1'b1;

    // x0 writebacks are accepted but never reach the register file.
    rf_we_d    = wb_fire && (wb_sel.rd != '0);
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (rf_we_d) begin
      rf_waddr_d = wb_sel.rd;
      rf_wdata_d = wb_sel.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  assign hazard_stall = rs1_busy | rs2_busy | (rsv_valid & rsv_busy);
  assign rsv_take     = rsv_valid && !hazard_stall && (rsv_rd != '0);

  // Busy clears on the same edge the register file captures, so stall drops
  // exactly when the read ports return the new value.
  regfile_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en    (rsv_take),
    .set_idx   (rsv_rd),
    .clr_en    (rf_we_q),
    .clr_idx   (rf_waddr_q),
    .lk_a_idx  (rs1_addr),
    .lk_b_idx  (rs2_addr),
    .lk_c_idx  (rsv_rd),
    .lk_a_busy (rs1_busy),
    .lk_b_busy (rs2_busy),
    .lk_c_busy (rsv_busy),
    .busy      (busy)
  );

  wb_to_unreserved: assert property (@(posedge clk) disable iff (rst)
    (wb_fire && wb_sel.rd != '0) |-> busy[wb_sel.rd])
    else $error("writeback to unreserved register x%0d", wb_sel.rd);

endmodule
